// File: rtl/gate_recv_cap_table.sv
// gate_recv_cap_table: capability-checked RX gate; head-beat route lookup forwards hits with their UL port, drops and counts misses.
// Define GATE_RECV_DEFAULT_UL_EN to forward misses to DEFAULT_UL instead of dropping them.
module gate_recv_cap_table #(
    parameter int N_DESTS    = 4,
    parameter int N_UL       = 4,
    parameter int DATA_BITS  = 512,
    parameter int ROUTE_BITS = 8,
    parameter int CNT_BITS   = 32,
    parameter int DEFAULT_UL = 0,
    localparam int UL_BITS   = (N_UL > 1) ? $clog2(N_UL) : 1,
    localparam int IDX_BITS  = (N_DESTS > 1) ? $clog2(N_DESTS) : 1
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  cap_wr_valid,
    input  logic [IDX_BITS-1:0]   cap_wr_idx,
    input  logic                  cap_wr_en,
    input  logic [ROUTE_BITS-1:0] cap_wr_route,
    input  logic [UL_BITS-1:0]    cap_wr_ul,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_BITS-1:0]  s_data,
    input  logic                  s_last,
    input  logic [ROUTE_BITS-1:0] s_route,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_BITS-1:0]  m_data,
    output logic                  m_last,
    output logic [UL_BITS-1:0]    m_ul,
    output logic [CNT_BITS-1:0]   drop_cnt,
    output logic                  drop_pulse
);
`ifdef GATE_RECV_DEFAULT_UL_EN
    localparam logic DEF_EN = 1'b1;
`else
    localparam logic DEF_EN = 1'b0;
`endif
    localparam logic [UL_BITS-1:0] DEF_UL = UL_BITS'(DEFAULT_UL);

    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

    state_t                state_q;
    logic [N_DESTS-1:0]    valid_q;
    logic [ROUTE_BITS-1:0] route_q [N_DESTS];
    logic [UL_BITS-1:0]    ul_q [N_DESTS];
    logic                  m_valid_q, m_last_q, drop_pulse_q;
    logic [DATA_BITS-1:0]  m_data_q;
    logic [UL_BITS-1:0]    m_ul_q;
    logic [CNT_BITS-1:0]   drop_cnt_q, drop_cnt_d;
    logic                  hit, fwd, s_fire, head_miss;
    logic [UL_BITS-1:0]    hit_ul;

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit    = 1'b0;
        hit_ul = DEF_UL;
        for (int i = N_DESTS - 1; i >= 0; i--)
            if (valid_q[i] && route_q[i] == s_route) begin
                hit    = 1'b1;
                hit_ul = ul_q[i];
            end
    end

    assign s_ready    = (state_q == DROP) || !m_valid_q || m_ready;
    assign s_fire     = s_valid && s_ready;
    assign head_miss  = s_fire && state_q == IDLE && !hit;
    assign fwd        = (state_q == PASS) || (state_q == IDLE && (hit || DEF_EN));
    assign drop_cnt_d = &drop_cnt_q ? drop_cnt_q : drop_cnt_q + 1'b1;

    always_ff @(posedge aclk) begin
        if (areset)
            valid_q <= '0;
        else if (cap_wr_valid)
            valid_q[cap_wr_idx] <= cap_wr_en;
    end

    always_ff @(posedge aclk) begin
        if (cap_wr_valid) begin
            route_q[cap_wr_idx] <= cap_wr_route;
            ul_q[cap_wr_idx]    <= cap_wr_ul;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= IDLE;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_last_q     <= 1'b0;
            m_ul_q       <= '0;
            drop_cnt_q   <= '0;
            drop_pulse_q <= 1'b0;
        end else begin
            drop_pulse_q <= head_miss;
            if (head_miss)
                drop_cnt_q <= drop_cnt_d;
            if (!m_valid_q || m_ready) begin
                m_valid_q <= s_fire && fwd;
                if (s_fire && fwd) begin
                    m_data_q <= s_data;
                    m_last_q <= s_last;
                    m_ul_q   <= (state_q == IDLE) ? hit_ul : m_ul_q;
                end
            end
            if (s_fire)
                state_q <= s_last ? IDLE : (state_q == IDLE ? (fwd ? PASS : DROP) : state_q);
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_last     = m_last_q;
    assign m_ul       = m_ul_q;
    assign drop_cnt   = drop_cnt_q;
    assign drop_pulse = drop_pulse_q;
endmodule

// File: tb/tb_gate_recv_cap_table.sv
// tb_gate_recv_cap_table: randomized and directed bench for gate_recv_cap_table against a packet-level reference model.
module tb_gate_recv_cap_table;
    localparam int ND = 4, DB = 64, RB = 8, CB = 4, UB = 2, DUL = 1;
`ifdef GATE_RECV_DEFAULT_UL_EN
    localparam bit DEF_EN = 1'b1;
`else
    localparam bit DEF_EN = 1'b0;
`endif

    logic          aclk = 1'b0, areset = 1'b1;
    logic          cap_wr_valid = 1'b0, cap_wr_en = 1'b0;
    logic [1:0]    cap_wr_idx = '0;
    logic [RB-1:0] cap_wr_route = '0;
    logic [UB-1:0] cap_wr_ul = '0;
    logic          s_valid = 1'b0, s_ready, s_last = 1'b0;
    logic [DB-1:0] s_data = '0;
    logic [RB-1:0] s_route = '0;
    logic          m_valid, m_ready = 1'b1, m_last, drop_pulse;
    logic [DB-1:0] m_data;
    logic [UB-1:0] m_ul;
    logic [CB-1:0] drop_cnt;

    always #5 aclk = ~aclk;

    gate_recv_cap_table #(.N_DESTS(ND), .N_UL(4), .DATA_BITS(DB), .ROUTE_BITS(RB),
                          .CNT_BITS(CB), .DEFAULT_UL(DUL)) dut (
        .aclk(aclk), .areset(areset), .cap_wr_valid(cap_wr_valid), .cap_wr_idx(cap_wr_idx),
        .cap_wr_en(cap_wr_en), .cap_wr_route(cap_wr_route), .cap_wr_ul(cap_wr_ul),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_route(s_route),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_ul(m_ul),
        .drop_cnt(drop_cnt), .drop_pulse(drop_pulse));

    typedef struct packed {logic [DB-1:0] d; logic l; logic [UB-1:0] u;} beat_t;

    beat_t         exp_q[$];
    bit            tv[ND];
    logic [RB-1:0] tr[ND];
    logic [UB-1:0] tu[ND];
    bit            in_pkt, pkt_fwd, pulse_exp, prev_stall, fired, wr_rand, hk_arm, hk_pend;
    logic [UB-1:0] pkt_ul, last_ul;
    beat_t         prev_b;
    int            cnt_m, n_out, pulses, rdy_pct = 100, hk_idx;
    int            errors = 0, checks = 0;

    // One cycle: inputs are already driven at the falling edge; observe, advance the model, move to next falling edge.
    task automatic tick();
        bit    exp_sr;
        int    hi;
        beat_t b;
        #1;
        exp_sr = (in_pkt && !pkt_fwd) || !m_valid || m_ready;
        checks++;
        if (s_ready !== exp_sr) begin errors++; $display("FAIL s_ready: got %b want %b @%0t", s_ready, exp_sr, $time); end
        checks++;
        if (drop_cnt !== CB'(cnt_m)) begin errors++; $display("FAIL drop_cnt: got %0d want %0d @%0t", drop_cnt, cnt_m, $time); end
        checks++;
        if (drop_pulse !== pulse_exp) begin errors++; $display("FAIL drop_pulse: got %b want %b @%0t", drop_pulse, pulse_exp, $time); end
        if (drop_pulse === 1'b1) pulses++;
        if (prev_stall) begin
            checks++;
            if (m_valid !== 1'b1 || {m_data, m_last, m_ul} !== prev_b) begin
                errors++; $display("FAIL stall_hold: got %b/%h want 1/%h @%0t", m_valid, {m_data, m_last, m_ul}, prev_b, $time);
            end
        end
        if (m_valid === 1'b1 && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL out_beat: got unexpected beat %h want none @%0t", {m_data, m_last, m_ul}, $time);
            end else begin
                b = exp_q.pop_front();
                if ({m_data, m_last, m_ul} !== b) begin
                    errors++; $display("FAIL out_beat: got %h want %h @%0t", {m_data, m_last, m_ul}, b, $time);
                end
            end
            n_out++;
            last_ul = m_ul;
        end
        pulse_exp = 1'b0;
        fired = s_valid && (s_ready === 1'b1);
        if (fired) begin
            if (!in_pkt) begin
                hi = -1;
                for (int i = 0; i < ND; i++)
                    if (hi < 0 && tv[i] && tr[i] == s_route) hi = i;
                pkt_fwd = (hi >= 0) || DEF_EN;
                pkt_ul  = (hi >= 0) ? tu[hi] : UB'(DUL);
                if (hi < 0) begin
                    if (cnt_m < (1 << CB) - 1) cnt_m++;
                    pulse_exp = 1'b1;
                end
            end
            if (pkt_fwd) exp_q.push_back({s_data, s_last, pkt_ul});
            in_pkt = !s_last;
        end
        if (cap_wr_valid) begin
            tv[cap_wr_idx] = cap_wr_en;
            tr[cap_wr_idx] = cap_wr_route;
            tu[cap_wr_idx] = cap_wr_ul;
        end
        prev_stall = m_valid && !m_ready;
        prev_b = {m_data, m_last, m_ul};
        @(negedge aclk);
    endtask

    task automatic wr(input int idx, input bit en, input logic [RB-1:0] route, input logic [UB-1:0] ul);
        s_valid = 1'b0; m_ready = 1'b1;
        cap_wr_valid = 1'b1; cap_wr_idx = 2'(idx); cap_wr_en = en; cap_wr_route = route; cap_wr_ul = ul;
        tick();
        cap_wr_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [RB-1:0] route, input int len, input int stall_beat);
        int n;
        for (int b = 0; b < len; b++) begin
            s_valid = 1'b1; s_data = {$urandom, $urandom}; s_last = (b == len - 1);
            s_route = (b == 0) ? route : RB'($urandom);
            n = 0;
            do begin
                m_ready = (b == stall_beat && n < 5) ? 1'b0 : ($urandom_range(99) < rdy_pct);
                cap_wr_valid = 1'b0;
                if (hk_pend) begin
                    cap_wr_valid = 1'b1; cap_wr_idx = 2'(hk_idx); cap_wr_en = 1'b0; hk_pend = 1'b0;
                end else if (wr_rand && $urandom_range(3) == 0) begin
                    cap_wr_valid = 1'b1; cap_wr_idx = 2'($urandom_range(ND - 1)); cap_wr_en = 1'($urandom);
                    cap_wr_route = RB'($urandom_range(3)); cap_wr_ul = UB'($urandom);
                end
                tick();
                n++;
            end while (!fired && n < 200);
            if (!fired) begin
                errors++; checks++; $display("FAIL beat_accept: got no handshake want handshake in 200 cycles");
            end
            if (b == 0 && hk_arm) begin hk_pend = 1'b1; hk_arm = 1'b0; end
        end
        s_valid = 1'b0; s_last = 1'b0; cap_wr_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        s_valid = 1'b0; cap_wr_valid = 1'b0; m_ready = 1'b1;
        while (exp_q.size() > 0 && n < 50) begin tick(); n++; end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL drain: got %0d pending want 0", exp_q.size()); end
        repeat (2) tick();
    endtask

    task automatic do_reset();
        areset = 1'b1; s_valid = 1'b0; cap_wr_valid = 1'b0; m_ready = 1'b1;
        repeat (2) @(negedge aclk);
        foreach (tv[i]) tv[i] = 1'b0;
        exp_q.delete();
        in_pkt = 0; pkt_fwd = 0; cnt_m = 0; pulse_exp = 0; prev_stall = 0;
        areset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks += 7;
        if (m_valid !== 1'b0)  begin errors++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        if (m_data !== '0)     begin errors++; $display("FAIL rst_m_data: got %h want 0", m_data); end
        if (m_last !== 1'b0)   begin errors++; $display("FAIL rst_m_last: got %b want 0", m_last); end
        if (m_ul !== '0)       begin errors++; $display("FAIL rst_m_ul: got %0d want 0", m_ul); end
        if (drop_cnt !== '0)   begin errors++; $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt); end
        if (drop_pulse !== 0)  begin errors++; $display("FAIL rst_drop_pulse: got %b want 0", drop_pulse); end
        if (s_ready !== 1'b1)  begin errors++; $display("FAIL rst_s_ready: got %b want 1", s_ready); end
        @(negedge aclk);
    endtask

    task automatic test_basic();
        int o0 = n_out;
        wr(0, 1, 8'h05, 2);
        send_pkt(8'h05, 3, -1);
        drain();
        checks += 3;
        if (n_out - o0 !== 3)  begin errors++; $display("FAIL basic_beats: got %0d want 3", n_out - o0); end
        if (last_ul !== 2'd2)  begin errors++; $display("FAIL basic_ul: got %0d want 2", last_ul); end
        if (drop_cnt !== '0)   begin errors++; $display("FAIL basic_drop_cnt: got %0d want 0", drop_cnt); end
    endtask

    task automatic test_drop();
        int o0 = n_out, p0 = pulses;
        wr(0, 0, 8'h05, 2);
        send_pkt(8'h09, 4, -1);
        drain();
        checks += 3;
        if (drop_cnt !== CB'(1)) begin errors++; $display("FAIL drop_cnt1: got %0d want 1", drop_cnt); end
        if (pulses - p0 !== 1)   begin errors++; $display("FAIL drop_pulses: got %0d want 1", pulses - p0); end
        if (n_out - o0 !== (DEF_EN ? 4 : 0)) begin errors++; $display("FAIL drop_beats: got %0d want %0d", n_out - o0, DEF_EN ? 4 : 0); end
    endtask

    task automatic test_priority();
        wr(0, 1, 8'h05, 2);
        wr(1, 1, 8'h05, 3);
        send_pkt(8'h05, 2, -1);
        drain();
        checks++;
        if (last_ul !== 2'd2) begin errors++; $display("FAIL prio_low_idx: got %0d want 2", last_ul); end
        wr(0, 0, 8'h05, 2);
        send_pkt(8'h05, 1, -1);
        drain();
        checks++;
        if (last_ul !== 2'd3) begin errors++; $display("FAIL prio_idx1: got %0d want 3", last_ul); end
    endtask

    task automatic test_revoke();
        int o0, c0;
        wr(1, 0, 8'h00, 0);
        wr(0, 1, 8'h05, 2);
        o0 = n_out;
        hk_arm = 1'b1; hk_idx = 0;
        send_pkt(8'h05, 4, -1);
        drain();
        checks += 2;
        if (n_out - o0 !== 4) begin errors++; $display("FAIL revoke_inflight_beats: got %0d want 4", n_out - o0); end
        if (last_ul !== 2'd2) begin errors++; $display("FAIL revoke_inflight_ul: got %0d want 2", last_ul); end
        o0 = n_out; c0 = cnt_m;
        send_pkt(8'h05, 2, -1);
        drain();
        checks += 3;
        if (drop_cnt !== CB'(c0 + 1)) begin errors++; $display("FAIL revoke_next_drop: got %0d want %0d", drop_cnt, c0 + 1); end
        if (n_out - o0 !== (DEF_EN ? 2 : 0)) begin errors++; $display("FAIL revoke_next_beats: got %0d want %0d", n_out - o0, DEF_EN ? 2 : 0); end
        if (last_ul !== (DEF_EN ? UB'(DUL) : 2'd2)) begin errors++; $display("FAIL revoke_next_ul: got %0d", last_ul); end
    endtask

    task automatic test_stall();
        int o0;
        wr(0, 1, 8'h05, 2);
        o0 = n_out;
        send_pkt(8'h05, 4, 2);
        drain();
        checks++;
        if (n_out - o0 !== 4) begin errors++; $display("FAIL stall_beats: got %0d want 4", n_out - o0); end
    endtask

    task automatic test_reset_mid();
        int o0;
        wr(0, 1, 8'h05, 2);
        s_valid = 1'b1; s_route = 8'h05; s_last = 1'b0; s_data = {$urandom, $urandom}; m_ready = 1'b0;
        tick();
        s_data = {$urandom, $urandom};
        tick();
        do_reset();
        #1;
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL midrst_m_valid: got %b want 0", m_valid); end
        @(negedge aclk);
        wr(0, 1, 8'h07, 1);
        o0 = n_out;
        send_pkt(8'h07, 1, -1);
        drain();
        checks += 2;
        if (n_out - o0 !== 1) begin errors++; $display("FAIL midrst_beats: got %0d want 1", n_out - o0); end
        if (last_ul !== 2'd1) begin errors++; $display("FAIL midrst_ul: got %0d want 1", last_ul); end
    endtask

    task automatic test_random();
        do_reset();
        wr_rand = 1'b1; rdy_pct = 60;
        for (int k = 0; k < 60; k++)
            send_pkt(RB'($urandom_range(3)), $urandom_range(1, 4), -1);
        wr_rand = 1'b0; rdy_pct = 100;
        drain();
    endtask

    task automatic test_saturate();
        int o0;
        do_reset();
        o0 = n_out;
        repeat (14) send_pkt(8'h09, 1, -1);
        drain();
        checks++;
        if (drop_cnt !== 4'd14) begin errors++; $display("FAIL sat_pre: got %0d want 14", drop_cnt); end
        repeat (3) send_pkt(8'h09, 1, -1);
        drain();
        checks += 2;
        if (drop_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt: got %0d want 15", drop_cnt); end
        if (n_out - o0 !== (DEF_EN ? 17 : 0)) begin errors++; $display("FAIL sat_beats: got %0d want %0d", n_out - o0, DEF_EN ? 17 : 0); end
    endtask

    initial begin
        @(negedge aclk);
        test_reset();
        test_basic();
        test_drop();
        test_priority();
        test_revoke();
        test_stall();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
